// File: rtl/bin2bcd_seq_if.sv
// Handshake/bus bundle for bin2bcd_seq: start/bin in, busy/valid/bcd out.
interface bin2bcd_seq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  valid;
  logic [4*DIGITS-1:0]   bcd;

  // Upstream side: requests conversions and consumes the settled digits.
  modport master (
    output start,
    output bin,
    input  busy,
    input  valid,
    input  bcd
  );

  // Converter side.
  modport slave (
    input  start,
    input  bin,
    output busy,
    output valid,
    output bcd
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Optional macro BIN2BCD_AUTO_EN: auto-start a conversion whenever bin differs
// from the last accepted value, so a free-running counter can drive bin with
// start tied low.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic          clk,
  input logic          rst,
  bin2bcd_seq_if.slave bus
);
  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  // DIGITS decimal digits must be able to hold the largest WIDTH-bit value.
  function automatic bit digits_ok();
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < DIGITS; i++) p = p * 64'd10;
    return p > ((64'd1 << WIDTH) - 64'd1);
  endfunction

  if (!digits_ok()) begin : g_bad_params
    $error("bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [SW-1:0]    scratch;
  logic [CW-1:0]    bitcnt;

  logic [SW-1:0]    adj;
  logic [SW-1:0]    scratch_next;
  logic [WIDTH-1:0] shift_next;
  logic             last;
  logic             launch;

`ifdef BIN2BCD_AUTO_EN
  logic [WIDTH-1:0] last_bin;
  assign launch = bus.start || (bus.bin != last_bin);
`else
  assign launch = bus.start;
`endif

  assign last = (bitcnt == CW'(WIDTH - 1));

  // Add-3 correction on each digit (no inter-digit carry), then shift left by one.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    scratch_next = {adj[SW-2:0], shift_reg[WIDTH-1]};
    shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
  end

  // Control FSM and datapath registers; bcd is written only at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      bitcnt    <= '0;
      bus.busy  <= 1'b0;
      bus.valid <= 1'b0;
      bus.bcd   <= '0;
`ifdef BIN2BCD_AUTO_EN
      last_bin  <= '0;
`endif
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            shift_reg <= bus.bin;
            scratch   <= '0;
            bitcnt    <= '0;
            bus.busy  <= 1'b1;
            state     <= SHIFT;
`ifdef BIN2BCD_AUTO_EN
            last_bin  <= bus.bin;
`endif
          end
        end
        SHIFT: begin
          scratch   <= scratch_next;
          shift_reg <= shift_next;
          bitcnt    <= bitcnt + CW'(1);
          if (last) begin
            bus.bcd   <= scratch_next;
            bus.valid <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq with a scoreboard of expected
// BCD results and completion cycles.
module tb_bin2bcd_seq;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [11:0] bcd;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc        = 0;
  int   checks     = 0;
  int   errors     = 0;
  int   valid_seen = 0;
  bit   auto_mode  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division.
  function automatic logic [11:0] bcd_of(input int v);
    logic [11:0] r;
    int t;
    t = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Start sampled at the next posedge (cyc+1); result visible WIDTH edges later.
  task automatic push_exp(input int v);
    exp_t e;
    e.bcd = bcd_of(v);
    e.due = cyc + 1 + int'(WIDTH);
    sb_q.push_back(e);
  endtask

  task automatic start_conv(input int v);
    @(negedge clk);
    bus.bin   = WIDTH'(v);
    bus.start = 1'b1;
    push_exp(v);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((bus.busy || sb_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(n < 40), 32'd1);
  endtask

  // Output monitor: every valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid) begin
      valid_seen++;
      if (!auto_mode) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("bcd", 32'(bus.bcd), 32'(e.bcd));
          check("latency", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int n;
    int dir_vals[6] = '{0, 9, 10, 99, 100, 200};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_bcd", 32'(bus.bcd), 32'd0);
    rst = 1'b0;

    // 255: busy for exactly WIDTH cycles, result held afterwards.
    start_conv(255);
    for (int i = 0; i < int'(WIDTH); i++) begin
      check("busy_hi", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    check("busy_lo", 32'(bus.busy), 32'd0);
    wait_done("c255");
    repeat (5) @(negedge clk);
    check("hold_255", 32'(bus.bcd), 32'h255);

    // Directed values, including digit-boundary cases.
    foreach (dir_vals[i]) begin
      start_conv(dir_vals[i]);
      wait_done("dir");
      check("dir_bcd", 32'(bus.bcd), 32'(bcd_of(dir_vals[i])));
    end

    // Start while busy is ignored; bin changes while busy have no effect.
    v0 = valid_seen;
    start_conv(42);
    repeat (2) @(negedge clk);
    bus.bin   = 8'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = 8'd42;
    wait_done("ign");
    repeat (4) @(negedge clk);
    check("ign_bcd", 32'(bus.bcd), 32'h042);
    check("ign_one_valid", valid_seen - v0, 32'd1);

    // Reset during the 4th SHIFT cycle aborts with no valid pulse.
    v0 = valid_seen;
    start_conv(123);
    repeat (3) @(negedge clk);
    rst     = 1'b1;
    bus.bin = '0;
    sb_q.delete();
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_valid", 32'(bus.valid), 32'd0);
    check("abort_bcd", 32'(bus.bcd), 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_valid", valid_seen - v0, 32'd0);
    start_conv(5);
    wait_done("post_rst");
    check("post_rst_bcd", 32'(bus.bcd), 32'h005);

    // Back-to-back: start accepted in the valid cycle.
    start_conv(17);
    n = 0;
    while (!bus.valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_valid", 32'(bus.valid), 32'd1);
    check("b2b_first_bcd", 32'(bus.bcd), 32'h017);
    bus.bin   = 8'd250;
    bus.start = 1'b1;
    push_exp(250);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_valid_drop", 32'(bus.valid), 32'd0);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done("b2b");
    check("b2b_bcd", 32'(bus.bcd), 32'h250);

`ifdef BIN2BCD_AUTO_EN
    // Counter drives bin directly with start low; display settles on final count.
    auto_mode = 1'b1;
    v0 = valid_seen;
    for (int c = 0; c <= 37; c++) begin
      @(negedge clk);
      bus.bin = 8'(c);
    end
    repeat (40) @(negedge clk);
    check("auto_launched", 32'(valid_seen > v0), 32'd1);
    check("auto_bcd", 32'(bus.bcd), 32'h037);
    check("auto_idle", 32'(bus.busy), 32'd0);
    v0 = valid_seen;
    repeat (30) @(negedge clk);
    check("auto_quiet", valid_seen - v0, 32'd0);
`else
    // Without auto-start, bin changes alone never launch a conversion.
    v0 = valid_seen;
    for (int c = 0; c <= 37; c++) begin
      @(negedge clk);
      bus.bin = 8'(c);
    end
    repeat (20) @(negedge clk);
    check("no_auto_busy", 32'(bus.busy), 32'd0);
    check("no_auto_valid", valid_seen - v0, 32'd0);
    check("no_auto_bcd", 32'(bus.bcd), 32'h250);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
